// File: rtl/ram_mem_ctrl_pkg.sv
// Shared types and defaults for the RAM initiator-side controller.
package ram_mem_pkg;

    localparam int DATA_W_DEF       = 4;
    localparam int ADDR_W_DEF       = 1;
    localparam int READ_LATENCY_DEF = 2;
    localparam int CNT_W            = 3;   // latency counter width, covers READ_LATENCY up to 7

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RESP,
        INIT
    } state_t;

endpackage

// File: rtl/ram_mem_ctrl_if.sv
// Request/response handshake plus RAM pin bundle for ram_mem_ctrl.
// master: bus initiator view, slave: controller view, ram: memory view.
interface ram_mem_ctrl_if
    import ram_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata,
        output mem_we, mem_addr, mem_wdata
    );

    modport ram (
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/ram_mem_ctrl.sv
// Initiator-side controller for a single-port synchronous RAM.
// One transaction at a time: accept in IDLE, drive the RAM pins, wait out
// the read latency, then hold the response until the consumer takes it.
// Optional build macro RAM_MEM_CTRL_INIT_EN: zero-fill the RAM after reset
// before the first request is accepted.
// DATA_W/ADDR_W must match the parameters of the connected interface.
module ram_mem_ctrl
    import ram_mem_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ram_mem_ctrl_if.slave  bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Ready is only offered in IDLE and never while reset is asserted.
    assign bus.req_ready = (state == IDLE) && !rst;

    // Main FSM; all response and RAM-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_MEM_CTRL_INIT_EN
            state <= INIT;
`else
            state <= IDLE;
`endif
            cnt           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= DATA_W'(0);
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_wdata <= bus.req_wdata;
                        bus.rsp_we    <= bus.req_we;
                        cnt           <= '0;
                        if (bus.req_we) begin
                            bus.mem_we <= 1'b1;
                            state      <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                // mem_we was high for exactly this cycle; the RAM commits on this edge.
                WRITE: begin
                    bus.mem_we    <= 1'b0;
                    bus.rsp_rdata <= DATA_W'(0);
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                // Address is held; capture RAM output once the latency has elapsed.
                READ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == CNT_W'(READ_LATENCY)) begin
                        bus.rsp_rdata <= bus.mem_rdata;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
`ifdef RAM_MEM_CTRL_INIT_EN
                // First INIT cycle starts the fill at address 0; stop after the top address.
                INIT: begin
                    bus.mem_wdata <= DATA_W'(0);
                    if (!bus.mem_we) begin
                        bus.mem_we   <= 1'b1;
                        bus.mem_addr <= ADDR_W'(0);
                    end else if (bus.mem_addr == {ADDR_W{1'b1}}) begin
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= ADDR_W'(0);
                        state        <= IDLE;
                    end else begin
                        bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_mem_ctrl.sv
// Self-checking bench for ram_mem_ctrl: directed scenarios followed by
// random traffic, checked against an array model of the RAM contents.
module tb_ram_mem_ctrl;
    import ram_mem_pkg::*;

    localparam int DW = 4;
    localparam int AW = 1;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_mem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM stand-in: latency counts from the edge that launches the address,
    // so RL=2 means one output register behind the array.
    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_q <= ram[bus.mem_addr];
    end
    assign bus.mem_rdata = rd_q;

    // Reference: what the RAM should contain, and whether it is defined yet.
    logic [DW-1:0] ref_mem   [2**AW];
    bit            ref_known [2**AW];

    int n_cmp = 0;
    int n_err = 0;
    bit tie_rdy = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply reset for one edge and check the post-reset behaviour.
    task automatic do_reset();
        int wecnt, rspcnt, first_rdy, exp_we, exp_rdy;
        bus.req_valid = 1'b0;
        bus.rsp_ready = tie_rdy;
        rst = 1'b1;
        #1;
        chk("rst_req_ready", int'(bus.req_ready), 0);
        step();
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_we",    int'(bus.rsp_we),    0);
        chk("rst_rsp_rdata", int'(bus.rsp_rdata), 0);
        chk("rst_mem_we",    int'(bus.mem_we),    0);
        chk("rst_mem_addr",  int'(bus.mem_addr),  0);
        chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
        rst = 1'b0;
        #1;
        wecnt = 0; rspcnt = 0; first_rdy = bus.req_ready ? 0 : -1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (bus.mem_we) begin
                chk("init_addr", int'(bus.mem_addr), wecnt);
                wecnt++;
            end
            if (bus.rsp_valid) rspcnt++;
            if (bus.req_ready && first_rdy < 0) first_rdy = i;
        end
`ifdef RAM_MEM_CTRL_INIT_EN
        exp_we = 2**AW; exp_rdy = 2**AW + 1;
        for (int a = 0; a < 2**AW; a++) begin
            ref_mem[a] = '0; ref_known[a] = 1'b1;
        end
`else
        exp_we = 0; exp_rdy = 0;
`endif
        chk("post_rst_we_cycles", wecnt, exp_we);
        chk("post_rst_rsp_valid", rspcnt, 0);
        chk("post_rst_first_ready", first_rdy, exp_rdy);
    endtask

    // One full transaction; hold = cycles of rsp_ready=0 in RESP,
    // poke = offer a competing write while the response is stalled.
    task automatic xact(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int hold, input bit poke);
        int t, waitc, wecnt, lowc, bad;
        logic [DW-1:0] rd0;
        logic          rwe;
        t = 0;
        while (!bus.req_ready && t < 50) begin step(); t++; end
        chk("req_ready_wait", int'(bus.req_ready), 1);
        if (!bus.req_ready) return;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        step();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        waitc = 0; wecnt = 0; lowc = 0; bad = 0;
        while (!bus.rsp_valid && waitc < 20) begin
            if (bus.mem_we) begin
                wecnt++;
                if (bus.mem_wdata !== d) bad++;
            end
            if (bus.mem_addr !== a) bad++;
            if (!bus.req_ready) lowc++;
            step();
            waitc++;
        end
        chk(we ? "wr_busy_cycles" : "rd_busy_cycles", waitc, we ? 1 : RL);
        rd0 = bus.rsp_rdata;
        rwe = bus.rsp_we;
        if (!bus.req_ready) lowc++;
        if (bus.mem_we) wecnt++;
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            if (poke) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = ~a;
                bus.req_wdata = ~d;
            end
            step();
            if (!bus.rsp_valid || bus.rsp_rdata !== rd0 || bus.rsp_we !== rwe) bad++;
            if (!bus.req_ready) lowc++;
            if (bus.mem_we) wecnt++;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        chk("rsp_valid_clear", int'(bus.rsp_valid), 0);
        chk("req_ready_back", int'(bus.req_ready), 1);
        bus.rsp_ready = tie_rdy;
        chk("req_ready_low", lowc, (we ? 1 : RL) + 1 + hold);
        chk("mem_we_cycles", wecnt, we ? 1 : 0);
        chk("hold_stable", bad, 0);
        chk("rsp_we", int'(rwe), int'(we));
        if (we) begin
            chk("wr_ack_rdata", int'(rd0), 0);
            ref_mem[a] = d;
            ref_known[a] = 1'b1;
        end else if (ref_known[a]) begin
            chk("rd_data", int'(rd0), int'(ref_mem[a]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int a = 0; a < 2**AW; a++) ref_known[a] = 1'b0;
        rst = 1'b1;
        step();
        do_reset();

        // write then read
        xact(1'b1, 1'b0, 4'b0110, 0, 1'b0);
        xact(1'b0, 1'b0, 4'b0000, 0, 1'b0);

        // back-to-back with rsp_ready tied high
        tie_rdy = 1'b1;
        bus.rsp_ready = 1'b1;
        xact(1'b1, 1'b1, 4'b1111, 0, 1'b0);
        xact(1'b0, 1'b1, 4'b0000, 0, 1'b0);
        tie_rdy = 1'b0;
        bus.rsp_ready = 1'b0;

        // response backpressure with a competing write that must be ignored
        xact(1'b0, 1'b0, 4'b0011, 5, 1'b1);
        xact(1'b0, 1'b1, 4'b0000, 0, 1'b0);

        // reset in the cycle after a read is accepted
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 1'b1;
        step();
        bus.req_valid = 1'b0;
        do_reset();
        xact(1'b0, 1'b1, 4'b0000, 0, 1'b0);

        // overwrite
        xact(1'b1, 1'b0, 4'b0110, 0, 1'b0);
        xact(1'b1, 1'b0, 4'b1100, 0, 1'b0);
        xact(1'b0, 1'b0, 4'b0000, 0, 1'b0);

        // random traffic
        for (int n = 0; n < 150; n++) begin
            xact(1'($urandom), AW'($urandom), DW'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
